// File: rtl/fpu_mul_arbiter.sv
// Round-robin front end and two-stage pipeline that shares one combinational
// single-precision multiplier among NUM_REQ requesters.
module fpu_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
  output logic                   rsp_exc,
  output logic                   rsp_ovf,
  output logic                   rsp_unf,
  input  logic                   rsp_ready,
  output logic [31:0]            mul_a,
  output logic [31:0]            mul_b,
  input  logic [31:0]            mul_result,
  input  logic                   mul_exc,
  input  logic                   mul_ovf,
  input  logic                   mul_unf,
  output logic                   busy
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] cand;
  logic            found;
  logic            accept;
  logic            load_p2;
  logic            free_p1;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;

  logic            vld_p1;
  logic [ID_W-1:0] id_p1;
  logic [31:0]     a_p1;
  logic [31:0]     b_p1;

  logic            vld_p2;
  logic [ID_W-1:0] id_p2;
  logic [31:0]     result_p2;
  logic [2:0]      flags_p2;

  assign load_p2 = vld_p1 & (~vld_p2 | rsp_ready);
  assign free_p1 = ~vld_p1 | load_p2;

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    grant = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign req_ready = (!RESET && free_p1 && found) ? (NUM_REQ'(1) << grant) : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  // Stage 1: operand registers feeding the shared multiplier
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p1 <= 1'b0;
      id_p1  <= '0;
      a_p1   <= '0;
      b_p1   <= '0;
      ptr    <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      vld_p1 <= 1'b1;
      id_p1  <= grant;
      a_p1   <= sel_a;
      b_p1   <= sel_b;
      ptr    <= grant;
    end else if (load_p2) begin
      vld_p1 <= 1'b0;
    end
  end

  assign mul_a = a_p1;
  assign mul_b = b_p1;

  // Stage 2: response registers capturing product and flags untouched
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p2    <= 1'b0;
      id_p2     <= '0;
      result_p2 <= '0;
      flags_p2  <= '0;
    end else if (load_p2) begin
      vld_p2    <= 1'b1;
      id_p2     <= id_p1;
      result_p2 <= mul_result;
      flags_p2  <= {mul_exc, mul_ovf, mul_unf};
    end else if (rsp_ready) begin
      vld_p2 <= 1'b0;
    end
  end

  assign rsp_valid  = vld_p2;
  assign rsp_id     = id_p2;
  assign rsp_result = result_p2;
  assign rsp_exc    = flags_p2[2];
  assign rsp_ovf    = flags_p2[1];
  assign rsp_unf    = flags_p2[0];
  assign busy       = vld_p1 | vld_p2;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter with a small lookup model of the multiplier.
module tb_fpu_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_exc, rsp_ovf, rsp_unf;
  logic                  rsp_ready;
  logic [31:0]           mul_a, mul_b;
  logic [31:0]           mul_result;
  logic                  mul_exc, mul_ovf, mul_unf;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  fpu_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_exc(rsp_exc), .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf), .rsp_ready(rsp_ready),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .mul_exc(mul_exc), .mul_ovf(mul_ovf), .mul_unf(mul_unf), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Known products for the directed vectors; anything else returns a ^ b.
  always_comb begin
    mul_result = mul_a ^ mul_b;
    mul_exc    = 1'b0;
    mul_ovf    = 1'b0;
    mul_unf    = 1'b0;
    if (mul_a == 32'h40000000 && mul_b == 32'h40400000) begin
      mul_result = 32'h40C00000;
    end else if (mul_a == 32'h3FC00000 && mul_b == 32'h3FC00000) begin
      mul_result = 32'h40100000;
    end else if (mul_a == 32'h7F800000 && mul_b == 32'h3F800000) begin
      mul_result = 32'h00000000;
      mul_exc    = 1'b1;
    end else if (mul_a == 32'h7F000000 && mul_b == 32'h7F000000) begin
      mul_result = 32'h7F800000;
      mul_ovf    = 1'b1;
    end else if (mul_a == 32'h00800000 && mul_b == 32'h00800000) begin
      mul_result = 32'h00000000;
      mul_unf    = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) cyc();
    RESET = 1'b0;
  endtask

  function automatic logic [31:0] fa(input int r);
    return 32'hA0000000 | 32'(r);
  endfunction

  function automatic logic [31:0] fb(input int r);
    return 32'h0B000000 | (32'(r) << 8);
  endfunction

  initial begin
    RESET     = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Reset state
    cyc();
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_flags", {rsp_exc, rsp_ovf, rsp_unf}, 0);

    // Single request, no contention
    do_reset();
    req_a[31:0] = 32'h40000000;
    req_b[31:0] = 32'h40400000;
    req_valid   = 4'b0001;
    rsp_ready   = 1'b1;
    #1;
    check("single_grant", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    #1;
    check("single_ready_off", req_ready, 0);
    check("single_early_rsp", rsp_valid, 0);
    check("single_busy", busy, 1);
    check("single_mul_a", mul_a, 32'h40000000);
    cyc();
    #1;
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_id", rsp_id, 0);
    check("single_result", rsp_result, 32'h40C00000);
    check("single_flags", {rsp_exc, rsp_ovf, rsp_unf}, 0);
    cyc();
    #1;
    check("single_drain", rsp_valid, 0);
    check("single_idle", busy, 0);

    // Full contention: round-robin grants, responses two cycles behind
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) begin
      req_a[32*r +: 32] = fa(r);
      req_b[32*r +: 32] = fb(r);
    end
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) req_valid = '0;
      #1;
      if (i < 8) check($sformatf("rr_grant%0d", i), req_ready, 64'(1 << (i % 4)));
      if (i >= 2) begin
        check($sformatf("rr_rsp_valid%0d", i), rsp_valid, 1);
        check($sformatf("rr_rsp_id%0d", i), rsp_id, 64'((i - 2) % 4));
        check($sformatf("rr_result%0d", i), rsp_result, fa((i - 2) % 4) ^ fb((i - 2) % 4));
      end
      cyc();
    end

    // Backpressure: two transactions held, then drained in order
    do_reset();
    req_a[63:32] = 32'h3FC00000;
    req_b[63:32] = 32'h3FC00000;
    req_a[95:64] = 32'h3FC00000;
    req_b[95:64] = 32'h3FC00000;
    req_valid    = 4'b0110;
    rsp_ready    = 1'b0;
    #1;
    check("bp_grant1", req_ready, 4'b0010);
    cyc();
    req_valid = 4'b0100;
    #1;
    check("bp_grant2", req_ready, 4'b0100);
    cyc();
    req_valid = '1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_stall_ready%0d", i), req_ready, 0);
      check($sformatf("bp_stall_valid%0d", i), rsp_valid, 1);
      check($sformatf("bp_stall_id%0d", i), rsp_id, 1);
      cyc();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    check("bp_rsp1_valid", rsp_valid, 1);
    check("bp_rsp1_id", rsp_id, 1);
    check("bp_rsp1_result", rsp_result, 32'h40100000);
    cyc();
    #1;
    check("bp_rsp2_valid", rsp_valid, 1);
    check("bp_rsp2_id", rsp_id, 2);
    check("bp_rsp2_result", rsp_result, 32'h40100000);
    cyc();
    #1;
    check("bp_no_dup", rsp_valid, 0);
    check("bp_idle", busy, 0);

    // Flag propagation, three back-to-back requests from requester 0
    do_reset();
    rsp_ready   = 1'b1;
    req_valid   = 4'b0001;
    req_a[31:0] = 32'h7F800000;
    req_b[31:0] = 32'h3F800000;
    #1;
    check("flag_grant_a", req_ready, 4'b0001);
    cyc();
    req_a[31:0] = 32'h7F000000;
    req_b[31:0] = 32'h7F000000;
    #1;
    check("flag_grant_b", req_ready, 4'b0001);
    cyc();
    req_a[31:0] = 32'h00800000;
    req_b[31:0] = 32'h00800000;
    #1;
    check("exc_flags", {rsp_exc, rsp_ovf, rsp_unf}, 3'b100);
    check("exc_result", rsp_result, 32'h00000000);
    cyc();
    req_valid = '0;
    #1;
    check("ovf_flags", {rsp_exc, rsp_ovf, rsp_unf}, 3'b010);
    check("ovf_result", rsp_result, 32'h7F800000);
    cyc();
    #1;
    check("unf_flags", {rsp_exc, rsp_ovf, rsp_unf}, 3'b001);
    check("unf_valid", rsp_valid, 1);

    // Reset with both stages full
    do_reset();
    req_a[31:0] = 32'h40000000;
    req_b[31:0] = 32'h40400000;
    rsp_ready   = 1'b0;
    req_valid   = 4'b0011;
    cyc();
    req_valid = 4'b0010;
    cyc();
    req_valid = '1;
    RESET     = 1'b1;
    #1;
    check("mid_full", {rsp_valid, busy}, 2'b11);
    check("mid_rst_ready", req_ready, 0);
    cyc();
    RESET = 1'b0;
    #1;
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_next_grant", req_ready, 4'b0001);
    cyc();
    req_valid = '0;

    // Pointer wrap
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    #1;
    check("wrap_grant3", req_ready, 4'b1000);
    cyc();
    req_valid = 4'b1001;
    #1;
    check("wrap_grant0", req_ready, 4'b0001);
    cyc();
    #1;
    check("wrap_grant3_again", req_ready, 4'b1000);
    cyc();
    req_valid = '0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_mul_arbiter.md
# fpu_mul_arbiter

Round-robin arbiter and two-stage pipeline wrapper that shares one combinational IEEE-754 single-precision multiplier among NUM_REQ requesters, such as neuron-update units and the CPU FPU issue path. It accepts one operand pair per cycle over a valid/ready handshake and drives the shared multiplier from a registered operand stage. The multiplier's result and Exception/Overflow/Underflow flags are captured in a response stage, and each response is returned to the originating requester with its own backpressure.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- ID_W, default 2: requester index width, equal to clog2(NUM_REQ).
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i set means requester i presents an operand pair.
- req_a  in  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, same packing as req_a.
- req_ready  out  NUM_REQ  one-hot or zero; bit i set means requester i is accepted this cycle.
- rsp_valid  out  1  response held in the response stage.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  32  product.
- rsp_exc, rsp_ovf, rsp_unf  out  1 each  captured multiplier flags.
- rsp_ready  in  1  owner (rsp_id) consumes the response this cycle.
- mul_a, mul_b  out  32  operands driven to the shared multiplier, taken directly from S1 registers.
- mul_result  in  32  multiplier result, combinational from mul_a/mul_b.
- mul_exc, mul_ovf, mul_unf  in  1 each  multiplier flags.
- busy  out  1  high when S1 or S2 is valid.

## Operation
- Stages:
  - S1 registers: s1_valid, s1_id, s1_a, s1_b.
  - S2 registers: s2_valid, s2_id, s2_result, s2_flags.
- Advance conditions:
  - s2_load = s1_valid & (~s2_valid | rsp_ready).
  - s1_free = ~s1_valid | s2_load.
- Arbitration, combinational each cycle:
  - Search req_valid starting at (ptr+1) mod NUM_REQ and wrapping upward.
  - The first set bit is the grant g.
  - req_ready = onehot(g) when s1_free and any req_valid; otherwise 0.
- Handshake: on req_valid[g] & req_ready[g], S1 loads {1, g, req_a[g], req_b[g]} and ptr <= g.
- ptr changes only on an accepted handshake.
- On s2_load, S2 loads {1, s1_id, mul_result, mul_exc/ovf/unf}.
- If s2_load occurs and no handshake occurs, s1_valid <= 0.
- If S2 is valid, rsp_ready is low and s2_load is 0, S2 holds and s2_valid stays 1.
- If rsp_ready is high and s1_valid is 0, s2_valid <= 0.
- Response outputs are S2 registers driven directly: rsp_valid = s2_valid, and so on.
- The block does no arithmetic of its own. Result and flags pass through unmodified, including the multiplier's exception encodings (result 0 with exc set).
- Requesters must hold req_a/req_b stable while req_valid is high and unaccepted. The block does not require this for correctness, because operands are sampled only on the accept cycle.
- Reset values:
  - s1_valid = 0, s2_valid = 0, ptr = NUM_REQ-1 (requester 0 wins first).
  - All data registers = 0, so rsp_result, mul_a, mul_b and flags read 0 and rsp_id reads 0.

## Timing
- Latency: request accepted at edge t; S1 valid after t; response visible (rsp_valid=1) after edge t+1. That is 2 cycles from the accept cycle to the first rsp_valid cycle, with no stall.
- Throughput: 1 accept per cycle when rsp_ready is held high.
- Stall: with rsp_ready low and both stages full, req_ready = 0 for all requesters. At most 2 transactions are in flight.
- Drain plus accept in the same cycle (S1 full, S2 draining) is legal and sustains full throughput.
- The multiplier path (S1 registers through mul_result into S2) is the critical combinational path. No other logic is inserted on it.
- Reset asserted mid-operation: both stages are invalidated at the next edge and in-flight results are discarded. req_ready is forced 0 while RESET is high.

## Test plan
- Single request, no contention: requester 0 sends 0x40000000 × 0x40400000 with rsp_ready=1. Required: req_ready[0] for 1 cycle; rsp_valid 2 cycles later with rsp_id=0, rsp_result=0x40C00000, all flags 0.
- Full contention, fairness: all 4 requesters hold req_valid for 8 cycles after reset. Required: grant order 0,1,2,3,0,1,2,3, one grant per cycle, rsp_id sequence matching and delayed by 2 cycles.
- Backpressure: requesters 1 and 2 each send 0x3FC00000 × 0x3FC00000 with rsp_ready=0 for 5 cycles. Required: both stages fill and req_ready stays 0. After rsp_ready=1, two consecutive responses of 0x40100000 arrive, ids 1 then 2, with no loss or duplication.
- Flag propagation:
  - 0x7F800000 × 0x3F800000: required rsp_exc=1, rsp_result=0x00000000.
  - 0x7F000000 × 0x7F000000: required rsp_ovf=1, rsp_result=0x7F800000.
- Reset mid-flight: assert RESET for 1 cycle while S1 and S2 are both valid. Required: rsp_valid=0 and busy=0 the next cycle, and the next grant goes to requester 0.
- Pointer wrap: only requester 3, then requesters 0 and 3 together. Required: grant 3, then grant 0, then grant 3.
